fp_seq_ctrl: RTL and testbench
==============================

// Module: fp_seq_ctrl
// PURPOSE
//  Sequencer for multi-cycle RV32F ops in the single-cycle core. Issues a start pulse to the FP unit.
//  Holds data_path (its stall input) until the unit answers, then retires the instruction in one
//  write-back cycle, steering the result to the FP regfile or the integer regfile (res_rd=2'b11, fp_2reg).
// PARAMETERS
//  OP_W            5    width of fp_op code from decoder
//  TIMEOUT_CYCLES  64   BUSY cycles before watchdog forces completion (FP_TIMEOUT_EN only); >=2
// PORTS
//  clk          in   1      single clock, rising edge
//  reset        in   1      synchronous, active-low; sampled on clk rising edge
//  fp_req       in   1      decoded instr at current pc needs the FP unit
//  fp_op        in   OP_W   op code; fp_op[OP_W-1]=1 means result goes to integer rd
//  fp_done      in   1      FP unit result valid, 1-cycle pulse
//  fp_result    in   32     FP unit result, valid with fp_done
//  fp_start     out  1      1-cycle issue pulse to FP unit
//  fp_op_q      out  OP_W   op latched at issue, held stable to FP unit until WB ends
//  stall        out  1      to data_path: 1 freezes pc
//  fp_wb_en     out  1      FP regfile write enable (WB cycle only)
//  int_wb_en    out  1      integer Reg_Write qualifier for FP->int ops (WB cycle only)
//  fp_2reg      out  32     registered result (to data_path mux4 input 3 and FP regfile wd)
//  fp_timeout   out  1      sticky watchdog error flag
// BEHAVIOUR
//  States: IDLE -> BUSY -> WB -> IDLE (2-bit encoding).
//  Reset (reset==0 at edge): state=IDLE, fp_op_q=0, fp_2reg=0, fp_timeout=0, wdog count=0.
//   Outputs are Moore/comb from state: after reset fp_start=0, stall=0, fp_wb_en=0, int_wb_en=0.
//  IDLE: fp_start=fp_req, stall=fp_req (combinational, same cycle).
//   fp_req=1 -> latch fp_op into fp_op_q, go BUSY. fp_done ignored in IDLE.
//  BUSY: stall=1, fp_start=0.
//   fp_done=1 -> fp_2reg<=fp_result, go WB. fp_req not re-sampled.
//  WB: stall=0, fp_wb_en=~fp_op_q[OP_W-1], int_wb_en=fp_op_q[OP_W-1].
//   pc advances at end of WB; always go IDLE next. fp_req still high in WB never re-issues.
//  Latency: issue to retire = unit latency L (>=1 cycle after start) + 1 WB cycle.
//   stall high for L+1 cycles, counting the issue cycle.
//  Simultaneous: fp_done in the fp_start cycle is not sampled (unit contract L>=1).
//   fp_done pulses outside BUSY are dropped.
//  Reset mid-op (BUSY or WB): abort to IDLE; no write enable asserted; FP unit shares reset.
//  Back-to-back FP instrs: second fp_req is seen in the IDLE cycle after WB. One bubble-free re-issue.
// CONFIGURATION
//  FP_TIMEOUT_EN defined:
//   Watchdog counts BUSY cycles from 0 and clears on entering BUSY.
//   At count==TIMEOUT_CYCLES-1 without fp_done, loads fp_2reg=32'h7FC00000 (canonical qNaN).
//   Then goes WB and sets fp_timeout=1 (sticky until reset).
//   fp_done in that same cycle wins: normal result, no flag.
//  FP_TIMEOUT_EN undefined: BUSY waits indefinitely; fp_timeout tied 0; no counter logic.
// STRUCTURE
//  Shared include fp_seq_defs.vh: state localparams (S_IDLE=0,S_BUSY=1,S_WB=2), CANON_QNAN, OP_W default,
//   to-int op-class bit index.
//  One sub-module: fp_wdog_cnt (clear, enable, terminal-count flag), instantiated only under FP_TIMEOUT_EN.
// TESTING
//  1 reset=0 two cycles, fp_req=1 -> all outputs 0, state IDLE, no fp_start.
//  2 fp_req=1 op=5'h03, fp_done 3 cycles after start with 32'h40490FDB:
//    -> stall high 4 cycles, fp_2reg=32'h40490FDB, fp_wb_en=1 for 1 cycle, int_wb_en=0.
//  3 op=5'h10 (to-int), L=1, result 32'h00000007 -> int_wb_en=1 in WB, fp_wb_en=0, stall high 2 cycles.
//  4 fp_done pulsed in IDLE and in WB -> ignored, no state change, fp_2reg unchanged.
//  5 reset=0 during BUSY -> next cycle IDLE, stall=0, no write enable.
//    A later fp_done with no request is ignored.
//  6 FP_TIMEOUT_EN, TIMEOUT_CYCLES=8, no fp_done -> WB after 8 BUSY cycles, fp_2reg=32'h7FC00000,
//    fp_timeout=1 held; without the macro -> stall stays 1 for 100+ cycles.

Source files
------------

// File: rtl/fp_seq_ctrl_pkg.sv
// Shared types and constants for the FP multi-cycle sequencer.
// CANON_QNAN exists only when FP_TIMEOUT_EN is defined.
package fp_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_WB   = 2'd2
    } state_e;

    localparam int OP_W_DEFAULT = 5;

`ifdef FP_TIMEOUT_EN
    localparam logic [31:0] CANON_QNAN = 32'h7FC0_0000;
`endif

    // The op-class bit selecting an integer destination is the op code MSB.
    function automatic int to_int_bit(input int op_w);
        return op_w - 1;
    endfunction

endpackage

// File: rtl/fp_wdog_cnt.sv
// Busy-cycle watchdog counter for fp_seq_ctrl; exists only when FP_TIMEOUT_EN is defined.
// tc flags the TERMINAL-th consecutive enabled cycle since the last clear.
`ifdef FP_TIMEOUT_EN
module fp_wdog_cnt #(
    parameter int TERMINAL = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CW = (TERMINAL > 2) ? $clog2(TERMINAL) : 1;
    localparam logic [CW-1:0] LAST = CW'(TERMINAL - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc = enable && (cnt_q == LAST);

    // Saturate at the terminal value; the sequencer leaves BUSY that same cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !tc) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/fp_seq_ctrl.sv
// Sequencer for multi-cycle RV32F ops: issue, stall the core while busy, one write-back cycle.
// Define FP_TIMEOUT_EN to add the busy watchdog that forces a qNaN result and a sticky flag.
module fp_seq_ctrl
    import fp_seq_ctrl_pkg::*;
#(
    parameter int OP_W           = OP_W_DEFAULT,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fp_req,
    input  logic [OP_W-1:0] fp_op,
    input  logic            fp_done,
    input  logic [31:0]     fp_result,
    output logic            fp_start,
    output logic [OP_W-1:0] fp_op_q,
    output logic            stall,
    output logic            fp_wb_en,
    output logic            int_wb_en,
    output logic [31:0]     fp_2reg,
    output logic            fp_timeout
);

    localparam int TO_INT_BIT = to_int_bit(OP_W);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("fp_seq_ctrl: TIMEOUT_CYCLES must be at least 2");
    end

    state_e          state_q;
    state_e          state_d;
    logic [OP_W-1:0] fp_op_d;
    logic [31:0]     fp_2reg_q;
    logic [31:0]     fp_2reg_d;

`ifdef FP_TIMEOUT_EN
    logic fp_timeout_q;
    logic fp_timeout_d;
    logic wdog_tc;
    logic wdog_clear;
    logic wdog_en;

    assign wdog_clear = (state_q == S_IDLE) && fp_req;
    assign wdog_en    = (state_q == S_BUSY);
    assign fp_timeout = fp_timeout_q;

    fp_wdog_cnt #(
        .TERMINAL (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (wdog_clear),
        .enable (wdog_en),
        .tc     (wdog_tc)
    );
`else
    assign fp_timeout = 1'b0;
`endif

    assign fp_2reg = fp_2reg_q;

    // Control outputs are forced low while reset is held so an aborted op never writes back.
    always_comb begin
        state_d   = state_q;
        fp_op_d   = fp_op_q;
        fp_2reg_d = fp_2reg_q;
`ifdef FP_TIMEOUT_EN
        fp_timeout_d = fp_timeout_q;
`endif
        fp_start  = 1'b0;
        stall     = 1'b0;
        fp_wb_en  = 1'b0;
        int_wb_en = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (fp_req) begin
                    fp_start = 1'b1;
                    stall    = 1'b1;
                    fp_op_d  = fp_op;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                stall = 1'b1;
                if (fp_done) begin
                    fp_2reg_d = fp_result;
                    state_d   = S_WB;
`ifdef FP_TIMEOUT_EN
                end else if (wdog_tc) begin
                    fp_2reg_d    = CANON_QNAN;
                    fp_timeout_d = 1'b1;
                    state_d      = S_WB;
`endif
                end
            end
            S_WB: begin
                fp_wb_en  = ~fp_op_q[TO_INT_BIT];
                int_wb_en = fp_op_q[TO_INT_BIT];
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (!reset) begin
            fp_start  = 1'b0;
            stall     = 1'b0;
            fp_wb_en  = 1'b0;
            int_wb_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            fp_op_q   <= '0;
            fp_2reg_q <= '0;
        end else begin
            state_q   <= state_d;
            fp_op_q   <= fp_op_d;
            fp_2reg_q <= fp_2reg_d;
        end
    end

`ifdef FP_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            fp_timeout_q <= 1'b0;
        end else begin
            fp_timeout_q <= fp_timeout_d;
        end
    end
`endif

endmodule

// File: tb/tb_fp_seq_ctrl.sv
// Randomized scoreboard bench for fp_seq_ctrl; adapts the hang/timeout scenario to FP_TIMEOUT_EN.
module tb_fp_seq_ctrl;

    localparam int OP_W = 5;
    localparam int TMO  = 8;
`ifdef FP_TIMEOUT_EN
    localparam int MAXL = TMO;
`else
    localparam int MAXL = 12;
`endif

    typedef struct {
        logic [OP_W-1:0] op;
        logic [31:0]     res;
        int              stall_cycles;
        bit              tmo;
    } exp_t;

    logic            clk;
    logic            reset;
    logic            fp_req;
    logic [OP_W-1:0] fp_op;
    logic            fp_done;
    logic [31:0]     fp_result;
    logic            fp_start;
    logic [OP_W-1:0] fp_op_q;
    logic            stall;
    logic            fp_wb_en;
    logic            int_wb_en;
    logic [31:0]     fp_2reg;
    logic            fp_timeout;

    exp_t        exp_q[$];
    int          checks;
    int          failures;
    logic [31:0] last_res;
    logic        tmo_model;
    int          stall_cnt;
    int          start_cnt;

    fp_seq_ctrl #(
        .OP_W           (OP_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fp_req     (fp_req),
        .fp_op      (fp_op),
        .fp_done    (fp_done),
        .fp_result  (fp_result),
        .fp_start   (fp_start),
        .fp_op_q    (fp_op_q),
        .stall      (stall),
        .fp_wb_en   (fp_wb_en),
        .int_wb_en  (int_wb_en),
        .fp_2reg    (fp_2reg),
        .fp_timeout (fp_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%08h expected=%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for n edges with a pending request, then release into IDLE.
    task automatic doReset(input int n);
        reset   = 1'b0;
        fp_req  = 1'b1;
        fp_op   = OP_W'($urandom);
        fp_done = 1'b0;
        exp_q.delete();
        repeat (n) nextCycle();
        checkOutput("rst_fp_op_q", 32'(fp_op_q), 32'd0);
        checkOutput("rst_fp_2reg", fp_2reg, 32'd0);
        checkOutput("rst_fp_timeout", 32'(fp_timeout), 32'd0);
        reset  = 1'b1;
        fp_req = 1'b0;
    endtask

    // One FP instruction: issue now, unit answers after lat busy cycles (or never if tmo).
    task automatic applyStimulus(input logic [OP_W-1:0] op, input int lat,
                                 input logic [31:0] res, input bit tmo);
        exp_t e;
        e.op           = op;
        e.res          = tmo ? 32'h7FC0_0000 : res;
        e.stall_cycles = lat + 1;
        e.tmo          = tmo;
        exp_q.push_back(e);
        fp_req    = 1'b1;
        fp_op     = op;
        fp_done   = 1'($urandom_range(0, 1));
        fp_result = $urandom;
        nextCycle();
        for (int c = 1; c <= lat; c++) begin
            fp_op = OP_W'($urandom);
            if (c == lat && !tmo) begin
                fp_done   = 1'b1;
                fp_result = res;
            end else begin
                fp_done   = 1'b0;
                fp_result = $urandom;
            end
            nextCycle();
        end
        fp_done   = 1'($urandom_range(0, 1));
        fp_result = $urandom;
        nextCycle();
        fp_done = 1'b0;
    endtask

    task automatic idleGap(input int n);
        fp_req = 1'b0;
        for (int c = 0; c < n; c++) begin
            fp_done   = 1'($urandom_range(0, 1));
            fp_result = $urandom;
            nextCycle();
        end
        fp_done = 1'b0;
    endtask

    // Monitor: every write-back pops one expected retirement; otherwise results must hold.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                checkOutput("reset_ctrl_outputs", {28'd0, fp_start, stall, fp_wb_en, int_wb_en}, 32'd0);
                last_res  = 32'd0;
                tmo_model = 1'b0;
                stall_cnt = 0;
                start_cnt = 0;
            end else begin
                if (fp_start) start_cnt++;
                if (stall) stall_cnt++;
                if (fp_wb_en || int_wb_en) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_wb actual fp_wb_en=%0b int_wb_en=%0b expected none at %0t",
                                 fp_wb_en, int_wb_en, $time);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("wb_result", fp_2reg, e.res);
                        checkOutput("wb_enables", {30'd0, fp_wb_en, int_wb_en},
                                    {30'd0, ~e.op[OP_W-1], e.op[OP_W-1]});
                        checkOutput("wb_op_latched", 32'(fp_op_q), 32'(e.op));
                        checkOutput("stall_cycles", 32'(stall_cnt), 32'(e.stall_cycles));
                        checkOutput("start_pulses", 32'(start_cnt), 32'd1);
                        if (e.tmo) tmo_model = 1'b1;
                        last_res = e.res;
                    end
                    stall_cnt = 0;
                    start_cnt = 0;
                end else begin
                    checkOutput("fp_2reg_hold", fp_2reg, last_res);
                end
                checkOutput("fp_timeout_flag", 32'(fp_timeout), 32'(tmo_model));
            end
        end
    end

    initial begin
        int hang_stalls;
        checks    = 0;
        failures  = 0;
        last_res  = 32'd0;
        tmo_model = 1'b0;
        stall_cnt = 0;
        start_cnt = 0;
        reset     = 1'b0;
        fp_req    = 1'b1;
        fp_op     = '0;
        fp_done   = 1'b0;
        fp_result = 32'd0;
        @(posedge clk);
        #1;
        doReset(2);
        idleGap(1);

        applyStimulus(5'h03, 3, 32'h4049_0FDB, 1'b0);
        idleGap(1);
        applyStimulus(5'h10, 1, 32'h0000_0007, 1'b0);
        idleGap(2);

        for (int i = 0; i < 30; i++) begin
            applyStimulus(OP_W'($urandom), $urandom_range(1, MAXL), $urandom, 1'b0);
            idleGap($urandom_range(0, 2));
        end

        // Abort in BUSY, then a stray fp_done with no request must be ignored.
        fp_req = 1'b1;
        fp_op  = 5'h05;
        nextCycle();
        nextCycle();
        doReset(1);
        checkOutput("abort_stall", 32'(stall), 32'd0);
        checkOutput("abort_fp_wb_en", 32'(fp_wb_en), 32'd0);
        fp_done   = 1'b1;
        fp_result = 32'hDEAD_BEEF;
        nextCycle();
        idleGap(3);

`ifdef FP_TIMEOUT_EN
        applyStimulus(5'h11, TMO, 32'd0, 1'b1);
        idleGap(2);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(OP_W'($urandom), $urandom_range(1, TMO), $urandom, 1'b0);
            idleGap($urandom_range(0, 1));
        end
        checkOutput("timeout_sticky", 32'(fp_timeout), 32'd1);
`else
        hang_stalls = 0;
        fp_req = 1'b1;
        fp_op  = 5'h07;
        nextCycle();
        for (int c = 0; c < 110; c++) begin
            fp_done = 1'b0;
            if (stall) hang_stalls++;
            nextCycle();
        end
        checkOutput("hang_stall_cycles", 32'(hang_stalls), 32'd110);
        doReset(2);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(OP_W'($urandom), $urandom_range(1, MAXL), $urandom, 1'b0);
            idleGap($urandom_range(0, 1));
        end
`endif

        idleGap(4);
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
